// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: groups the per-channel source buffer signals and the
// registered output stream shared by the frame scheduler and its neighbours.
// The master modport is the scheduler's side of the bus.
interface fft_frame_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    req;
  logic [16*NUM_CH-1:0] src_data;
  logic [NUM_CH-1:0]    src_rd;
  logic [NUM_CH-1:0]    grant;
  logic [15:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  req, src_data, out_ready,
    output src_rd, grant, out_data, out_valid
  );

  modport slave (
    output req, src_data, out_ready,
    input  src_rd, grant, out_data, out_valid
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: round-robin arbiter that frames one FFT result buffer
// at a time onto a shared, backpressurable 16-bit stream.
// Frame layout: HDR_LEN x 16'hFFFF, 16'hA500|ch, FRAME_LEN payload words.
// Optional feature macro FRAME_CHECKSUM_EN appends a two's-complement trailer
// word so that payload plus trailer sums to zero modulo 2^16.
module fft_frame_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 16,
  parameter int HDR_LEN   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_frame_scheduler_if.master bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int HDR_W = $clog2(HDR_LEN + 1);
  localparam int PAY_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_HDR,
    S_ID,
    S_PAY,
`ifdef FRAME_CHECKSUM_EN
    S_TRL,
`endif
    S_END
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   rr_last;
  logic [CH_W-1:0]   arb_ch;
  logic              arb_found;
  logic [HDR_W-1:0]  hdr_cnt;
  logic [PAY_W-1:0]  pay_cnt;
  logic              load;
  logic [15:0]       words [NUM_CH];
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]       sum;
`endif

  // Slice the flat source bus into one word per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_words
    assign words[g] = bus.src_data[16*g +: 16];
  end

  // The output register may take a new word when it is empty or being drained.
  assign load = !bus.out_valid || bus.out_ready;
  assign busy = (state != S_IDLE);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] idx_c;
    arb_ch    = '0;
    arb_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(rr_last) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (!arb_found && bus.req[idx_c]) begin
        arb_found = 1'b1;
        arb_ch    = idx_c;
      end
    end
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode plus the combinational pop strobe and done pulse.
  always_comb begin
    next_state = state;
    bus.src_rd = '0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: if (|bus.req) next_state = S_ARB;
      S_ARB:  next_state = arb_found ? S_HDR : S_IDLE;
      S_HDR:  if (load && hdr_cnt == HDR_W'(HDR_LEN - 1)) next_state = S_ID;
      S_ID:   if (load) next_state = S_PAY;
      S_PAY: begin
        if (load) bus.src_rd = NUM_CH'(1) << ch;
        if (load && pay_cnt == PAY_W'(FRAME_LEN - 1)) begin
`ifdef FRAME_CHECKSUM_EN
          next_state = S_TRL;
`else
          next_state = S_END;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_TRL:  if (load) next_state = S_END;
`endif
      S_END: begin
        if (bus.out_valid && bus.out_ready) begin
          frame_done = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: grant/channel capture, counters and the registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.grant     <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      ch            <= '0;
      rr_last       <= CH_W'(NUM_CH - 1);
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
`ifdef FRAME_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      unique case (state)
        S_ARB: begin
`ifdef FRAME_CHECKSUM_EN
          sum <= '0;
`endif
          if (arb_found) begin
            ch        <= arb_ch;
            bus.grant <= NUM_CH'(1) << arb_ch;
            rr_last   <= arb_ch;
            hdr_cnt   <= '0;
          end
        end
        S_HDR: if (load) begin
          bus.out_data  <= 16'hFFFF;
          bus.out_valid <= 1'b1;
          hdr_cnt       <= hdr_cnt + HDR_W'(1);
        end
        S_ID: if (load) begin
          bus.out_data  <= 16'hA500 | {8'h00, 8'(ch)};
          bus.out_valid <= 1'b1;
          pay_cnt       <= '0;
        end
        S_PAY: if (load) begin
          bus.out_data  <= words[ch];
          bus.out_valid <= 1'b1;
          pay_cnt       <= pay_cnt + PAY_W'(1);
`ifdef FRAME_CHECKSUM_EN
          sum           <= sum + words[ch];
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        S_TRL: if (load) begin
          bus.out_data  <= ~sum + 16'd1;
          bus.out_valid <= 1'b1;
        end
`endif
        S_END: if (bus.out_valid && bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.grant     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed self-checking bench for fft_frame_scheduler
// with NUM_CH=4, FRAME_LEN=4, HDR_LEN=3. Inputs change and outputs are
// sampled around the falling clock edge. Honours FRAME_CHECKSUM_EN.
module tb_fft_frame_scheduler;
  localparam int NUM_CH    = 4;
  localparam int FRAME_LEN = 4;
  localparam int HDR_LEN   = 3;
`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_WORDS = HDR_LEN + 1 + FRAME_LEN + 1;
`else
  localparam int FRAME_WORDS = HDR_LEN + 1 + FRAME_LEN;
`endif

  logic clk;
  logic rst_n;
  logic busy;
  logic frame_done;

  fft_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  fft_frame_scheduler #(
    .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .HDR_LEN(HDR_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0]       pay_mem [NUM_CH][16];
  int                rd_idx  [NUM_CH];
  logic [NUM_CH-1:0] pend_pop;
  logic [15:0]       acc_q [$];
  logic [15:0]       exp_q [$];
  logic [3:0]        bp_pat = 4'b1001;

  logic              s_valid, s_busy, s_done;
  logic [15:0]       s_data;
  logic [NUM_CH-1:0] s_rd, s_grant;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: retire pops from the previous edge, drive inputs, sample outputs.
  task automatic step(input logic [3:0] req_v, input logic ready_v);
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) if (pend_pop[i]) rd_idx[i]++;
    pend_pop = '0;
    for (int i = 0; i < NUM_CH; i++) bus.src_data[16*i +: 16] = pay_mem[i][rd_idx[i] % 16];
    bus.req       = req_v;
    bus.out_ready = ready_v;
    #1;
    s_valid  = bus.out_valid;
    s_data   = bus.out_data;
    s_rd     = bus.src_rd;
    s_grant  = bus.grant;
    s_busy   = busy;
    s_done   = frame_done;
    pend_pop = s_rd;
  endtask

  // Loads a channel's 4-word payload and builds the expected frame.
  task automatic setup_frame(input int ch, input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3);
    logic [15:0] sum;
    pay_mem[ch][0] = p0; pay_mem[ch][1] = p1; pay_mem[ch][2] = p2; pay_mem[ch][3] = p3;
    rd_idx[ch] = 0;
    exp_q.delete();
    repeat (HDR_LEN) exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hA500 | 16'(ch));
    exp_q.push_back(p0); exp_q.push_back(p1); exp_q.push_back(p2); exp_q.push_back(p3);
    sum = p0 + p1 + p2 + p3;
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(~sum + 16'd1);
`endif
  endtask

  // Runs one frame and records what the stream and source side did.
  task automatic run_frame(input logic [3:0] req_v, input bit keep_req, input bit bp,
                           output int first_valid, output int done_at, output int n_rd,
                           output logic [3:0] rd_or, output logic [3:0] grant_seen,
                           output int stall_bad);
    logic [3:0]  r;
    logic        rdy;
    logic        prev_stall;
    logic [15:0] prev_data;
    acc_q.delete();
    first_valid = -1; done_at = -1; n_rd = 0; rd_or = '0; grant_seen = '0; stall_bad = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int s = 0; s < 80 && done_at < 0; s++) begin
      r   = (keep_req || s < 2) ? req_v : 4'b0000;
      rdy = bp ? bp_pat[s % 4] : 1'b1;
      step(r, rdy);
      if (prev_stall && (!s_valid || s_data !== prev_data)) stall_bad++;
      if (s_valid && !rdy && s_rd != '0) stall_bad++;
      if (s_valid && first_valid < 0) first_valid = s;
      if (s_grant != '0) grant_seen = s_grant;
      if (s_rd != '0) begin n_rd++; rd_or |= s_rd; end
      if (s_valid && rdy) acc_q.push_back(s_data);
      if (s_done) done_at = s;
      prev_stall = s_valid && !rdy;
      prev_data  = s_data;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 4'b1111; bus.out_ready = 1'b1; bus.src_data = '0; pend_pop = '0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_data: got %h want 0000", bus.out_data); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant: got %b want 0000", bus.grant); end
    total++; if (bus.src_rd !== 4'b0000) begin bad++; $display("[TB] FAIL reset_src_rd: got %b want 0000", bus.src_rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
    bus.req = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    int fv, da, nr, sb; logic [3:0] ro, gs;
    setup_frame(2, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    run_frame(4'b0100, 1'b0, 1'b0, fv, da, nr, ro, gs, sb);
    total++; if (fv !== 3) begin bad++; $display("[TB] FAIL single_first_valid: got %0d want 3", fv); end
    total++; if (da !== 2 + FRAME_WORDS) begin bad++; $display("[TB] FAIL single_done_step: got %0d want %0d", da, 2 + FRAME_WORDS); end
    total++; if (nr !== FRAME_LEN) begin bad++; $display("[TB] FAIL single_rd_count: got %0d want %0d", nr, FRAME_LEN); end
    total++; if (ro !== 4'b0100) begin bad++; $display("[TB] FAIL single_rd_mask: got %b want 0100", ro); end
    total++; if (gs !== 4'b0100) begin bad++; $display("[TB] FAIL single_grant: got %b want 0100", gs); end
    total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL single_len: got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL single_word%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    step(4'b0000, 1'b1);
    total++; if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_grant !== 4'b0000) begin
      bad++; $display("[TB] FAIL single_idle_after: got busy=%b valid=%b grant=%b want 0 0 0000", s_busy, s_valid, s_grant);
    end
  endtask

  task automatic test_round_robin();
    int fv, da, nr, sb; logic [3:0] ro, gs;
    @(negedge clk); rst_n = 1'b0; pend_pop = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) rd_idx[c] = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(4'b1111, 1'b1, 1'b0, fv, da, nr, ro, gs, sb);
      total++; if (gs !== (4'b0001 << f)) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b want %b", f, gs, 4'b0001 << f); end
      total++; if (acc_q.size() < 4 || acc_q[3] !== (16'hA500 | 16'(f))) begin
        bad++; $display("[TB] FAIL rr_id%0d: got %h want %h", f, (acc_q.size() < 4) ? 16'h0 : acc_q[3], 16'hA500 | 16'(f));
      end
    end
    run_frame(4'b1001, 1'b0, 1'b0, fv, da, nr, ro, gs, sb);
    total++; if (gs !== 4'b0001) begin bad++; $display("[TB] FAIL rr_wrap_grant: got %b want 0001", gs); end
  endtask

  task automatic test_backpressure();
    int fv, da, nr, sb; logic [3:0] ro, gs;
    setup_frame(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_frame(4'b0010, 1'b0, 1'b1, fv, da, nr, ro, gs, sb);
    total++; if (da < 0) begin bad++; $display("[TB] FAIL bp_timeout: got %0d want done step", da); end
    total++; if (gs !== 4'b0010) begin bad++; $display("[TB] FAIL bp_grant: got %b want 0010", gs); end
    total++; if (nr !== FRAME_LEN) begin bad++; $display("[TB] FAIL bp_rd_count: got %0d want %0d", nr, FRAME_LEN); end
    total++; if (sb !== 0) begin bad++; $display("[TB] FAIL bp_stall: got %0d violations want 0", sb); end
    total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL bp_len: got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL bp_word%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_checksum();
    int fv, da, nr, sb; logic [3:0] ro, gs;
    setup_frame(2, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF);
    run_frame(4'b0100, 1'b0, 1'b0, fv, da, nr, ro, gs, sb);
`ifdef FRAME_CHECKSUM_EN
    total++; if (acc_q.size() !== 9) begin bad++; $display("[TB] FAIL cks_len: got %0d want 9", acc_q.size()); end
    total++; if (acc_q.size() > 0 && acc_q[acc_q.size()-1] !== 16'hFFFB) begin
      bad++; $display("[TB] FAIL cks_trailer: got %h want FFFB", acc_q[acc_q.size()-1]);
    end
    total++; if (da !== 11) begin bad++; $display("[TB] FAIL cks_done_step: got %0d want 11", da); end
`else
    total++; if (acc_q.size() !== 8) begin bad++; $display("[TB] FAIL cks_len: got %0d want 8", acc_q.size()); end
    total++; if (da !== 10) begin bad++; $display("[TB] FAIL cks_done_step: got %0d want 10", da); end
`endif
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL cks_word%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_arb_race();
    int busy_n = 0;
    int out_n  = 0;
    step(4'b0001, 1'b1);
    for (int s = 0; s < 6; s++) begin
      step(4'b0000, 1'b1);
      if (s_busy) busy_n++;
      if (s_valid || s_grant != '0 || s_rd != '0) out_n++;
    end
    total++; if (busy_n !== 1) begin bad++; $display("[TB] FAIL race_busy_cycles: got %0d want 1", busy_n); end
    total++; if (out_n !== 0) begin bad++; $display("[TB] FAIL race_output: got %0d active cycles want 0", out_n); end
  endtask

  task automatic test_reset_mid_pay();
    int fv, da, nr, sb; logic [3:0] ro, gs;
    int acc = 0;
    setup_frame(3, 16'h3001, 16'h3002, 16'h3003, 16'h3004);
    for (int s = 0; s < 30 && acc < HDR_LEN + 1 + 2; s++) begin
      step((s < 2) ? 4'b1000 : 4'b0000, 1'b1);
      if (s_valid) acc++;
    end
    total++; if (acc !== HDR_LEN + 3) begin bad++; $display("[TB] FAIL rst_mid_reach: got %0d words want %0d", acc, HDR_LEN + 3); end
    #2; rst_n = 1'b0; #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("[TB] FAIL rst_mid_grant: got %b want 0000", bus.grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    pend_pop = '0;
    @(negedge clk); rst_n = 1'b1;
    setup_frame(0, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
    run_frame(4'b1111, 1'b0, 1'b0, fv, da, nr, ro, gs, sb);
    total++; if (gs !== 4'b0001) begin bad++; $display("[TB] FAIL rst_mid_next_grant: got %b want 0001", gs); end
    total++; if (fv !== 3) begin bad++; $display("[TB] FAIL rst_mid_first_valid: got %0d want 3", fv); end
    total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rst_mid_len: got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rst_mid_word%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
  endtask

  // Scenario sequence followed by the one-line summary.
  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      rd_idx[i] = 0;
      for (int j = 0; j < 16; j++) pay_mem[i][j] = 16'(i * 256 + j);
    end
    $display("[TB] starting fft_frame_scheduler bench");
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_checksum();
    test_arb_race();
    test_reset_mid_pay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares one serial output link between NUM_CH FFT result buffers.
- Each frame is wrapped with HDR_LEN sync words of 16'hFFFF, a channel-ID word, then FRAME_LEN payload words.
- Round-robin arbitration picks the channel; the block pops that buffer and drives a registered, backpressurable 16-bit stream toward the UART/packet stage.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- FRAME_LEN, 16, payload words per frame (1..1023).
- HDR_LEN, 3, sync words of 16'hFFFF emitted before the ID word (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel frame-ready request; a channel asserts only when a full frame is buffered.
- src_data  in  16*NUM_CH  per-channel head-of-buffer word; channel i uses bits [16i+15:16i].
- src_rd  out  NUM_CH  one-hot pop strobe to the granted channel; combinational.
- grant  out  NUM_CH  one-hot registered grant; held from first header word through the last word of the frame.
- out_data  out  16  output word, registered.
- out_valid  out  1  out_data valid, registered.
- out_ready  in  1  downstream accepts a word when out_valid && out_ready.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse on the cycle the last frame word is accepted.

Behaviour:
- Reset values: grant=0, out_data=0, out_valid=0, busy=0, frame_done=0, src_rd=0, FSM=IDLE, rr_last=NUM_CH-1 (channel 0 wins first).
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately. No partial-frame recovery; the source re-requests.
- load = !out_valid || out_ready. The output register loads only when load=1; otherwise out_data and out_valid hold stable.
- FSM states: IDLE, ARB, HDR, ID, PAY, [TRL], END.
- IDLE: if |req then ARB.
- ARB (1 cycle): pick the first requesting channel scanning rr_last+1, rr_last+2, … with wrap. Set ch, grant, rr_last=ch, hdr_cnt=0, then HDR.
  - If req has dropped to 0 by ARB, return to IDLE with no output.
- HDR: on load, out_data=16'hFFFF, out_valid=1, hdr_cnt++. After HDR_LEN loads, go to ID.
- ID: on load, out_data = 16'hA500 | ch (ch in bits [7:0]). Go to PAY; pay_cnt=0.
- PAY: src_rd[ch] = load. On load, out_data = src_data[ch]; pay_cnt++. After FRAME_LEN loads, go to TRL if enabled, else END.
- END: wait until the last word is accepted (out_valid && out_ready). That cycle: frame_done=1, grant=0, out_valid=0 (unless already reloaded; no new word loads in END), then IDLE.
- Latency: req high sampled at edge k → ARB during cycle k+1 → first header word out_valid at edge k+2.
- Without backpressure, a frame occupies exactly HDR_LEN+1+FRAME_LEN(+1) consecutive valid cycles.
- Minimum gap between frames: 2 idle cycles (END→IDLE→ARB).
- req changes while a frame is in progress are ignored; a new request is arbitrated only after END.
- All counters are sized to clog2 of their maximum and never wrap mid-frame.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator clears in ARB and adds each payload word modulo 2^16 as it is loaded.
  - TRL state emits one extra word, out_data = ~sum + 1, so that payload plus trailer sums to 0 mod 2^16.
  - frame_done fires on acceptance of the trailer.
- Undefined: no accumulator and no TRL state; PAY goes directly to END.

Test Plan:
- Single channel, out_ready=1, NUM_CH=4, FRAME_LEN=4, req[2]=1, payload 1,2,3,4 → output FFFF,FFFF,FFFF,A502,0001,0002,0003,0004 on 8 consecutive cycles; first valid 2 edges after req; src_rd[2] high on exactly 4 cycles; frame_done on the 8th.
- Round-robin: req=4'b1111 held for 4 frames → grant order 0,1,2,3; with req=4'b1001 after channel 3 → next grant is channel 0.
- Backpressure: out_ready toggled 1,0,0,1 repeating during PAY → out_data stable while stalled; no src_rd during stalls; payload order intact; total src_rd pulses = FRAME_LEN.
- Reset mid-PAY (rst_n low 1 cycle after 2 payload words) → out_valid, grant, busy drop asynchronously; next frame starts at channel 0 with full headers.
- FRAME_CHECKSUM_EN with payload 0x0001,0x0002,0x0003,0xFFFF → trailer 0xFFFB (sum 0x0005); frame length 9 words.
- ARB race: req pulses for 1 cycle only in IDLE → FSM returns to IDLE, no output, busy high for exactly 1 cycle.
